// File: rtl/button_events_if.sv
// rtl/button_events_if.sv - button level in, single-cycle user-input events out
interface button_events_if;
    logic button;
    logic held;
    logic press;
    logic release_pulse;
    logic click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;

    // Source of the debounced level, consumer of the events
    modport master (
        output button,
        input  held, press, release_pulse, click, double_click, long_press, repeat_pulse
    );

    // Event generator
    modport slave (
        input  button,
        output held, press, release_pulse, click, double_click, long_press, repeat_pulse
    );
endinterface

// File: rtl/button_events.sv
// rtl/button_events.sv - press/release/click/double/long/repeat event generator
module button_events #(
    parameter int LONG_CYCLES   = 500000,
    parameter int DOUBLE_CYCLES = 250000,
    parameter int REPEAT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset_low,
    button_events_if.slave bus
);
    localparam int MAX_LD = (LONG_CYCLES > DOUBLE_CYCLES) ? LONG_CYCLES : DOUBLE_CYCLES;
    localparam int MAX_V  = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_V + 1);

    typedef logic [CW-1:0] cnt_t;

    // Terminal compare values: an event fires when the count reaches N-1,
    // which lands the registered pulse exactly N cycles after the start.
    localparam cnt_t LONG_END   = cnt_t'(LONG_CYCLES - 1);
    localparam cnt_t DOUBLE_END = cnt_t'((DOUBLE_CYCLES == 0) ? 0 : DOUBLE_CYCLES - 1);
    localparam cnt_t REPEAT_END = cnt_t'(REPEAT_CYCLES - 1);
    localparam cnt_t CNT_SAT    = '1;

    typedef enum logic [2:0] {
        S_LOCKOUT, S_IDLE, S_HELD1, S_WAIT, S_HELD2, S_LONG
    } state_t;

    state_t state, next_state;
    cnt_t   count;

    logic held_d, press_d, release_d, click_d, double_d, long_d, repeat_d;

    logic long_hit, double_hit, repeat_hit;
    assign long_hit   = (count == LONG_END);
    assign double_hit = (count == DOUBLE_END);
    assign repeat_hit = (count == REPEAT_END);

    // State, counter and registered event outputs
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state             <= S_LOCKOUT;
            count             <= '0;
            bus.held          <= 1'b0;
            bus.press         <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.click         <= 1'b0;
            bus.double_click  <= 1'b0;
            bus.long_press    <= 1'b0;
            bus.repeat_pulse  <= 1'b0;
        end else begin
            state <= next_state;
            // Restart timing on any state change and on each repeat period
            if ((next_state != state) || repeat_d)
                count <= '0;
            else if (count != CNT_SAT)
                count <= count + cnt_t'(1);
            bus.held          <= held_d;
            bus.press         <= press_d;
            bus.release_pulse <= release_d;
            bus.click         <= click_d;
            bus.double_click  <= double_d;
            bus.long_press    <= long_d;
            bus.repeat_pulse  <= repeat_d;
        end
    end

    // Next-state decision; a button edge always takes precedence over a timeout
    always_comb begin
        next_state = state;
        case (state)
            S_LOCKOUT: if (!bus.button) next_state = S_IDLE;
            S_IDLE:    if (bus.button)  next_state = S_HELD1;
            S_HELD1: begin
                if (!bus.button)
                    next_state = (DOUBLE_CYCLES == 0) ? S_IDLE : S_WAIT;
                else if (long_hit)
                    next_state = S_LONG;
            end
            S_WAIT: begin
                if (bus.button)
                    next_state = S_HELD2;
                else if (double_hit)
                    next_state = S_IDLE;
            end
            S_HELD2: begin
                if (!bus.button)
                    next_state = S_IDLE;
                else if (long_hit)
                    next_state = S_LONG;
            end
            S_LONG:    if (!bus.button) next_state = S_IDLE;
            default:   next_state = S_LOCKOUT;
        endcase
    end

    // Event decode for the next cycle's registered outputs
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state)
            S_IDLE: press_d = bus.button;
            S_HELD1: begin
                if (!bus.button) begin
                    release_d = 1'b1;
                    click_d   = (DOUBLE_CYCLES == 0);
                end else if (long_hit) begin
                    long_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.button)
                    press_d = 1'b1;
                else if (double_hit)
                    click_d = 1'b1;
            end
            S_HELD2: begin
                if (!bus.button) begin
                    release_d = 1'b1;
                    double_d  = 1'b1;
                end else if (long_hit) begin
                    long_d = 1'b1;
                end
            end
            S_LONG: begin
                if (!bus.button)
                    release_d = 1'b1;
                else if (repeat_hit)
                    repeat_d = 1'b1;
            end
            default: ;
        endcase
        held_d = (next_state == S_HELD1) || (next_state == S_HELD2) || (next_state == S_LONG);
    end
endmodule
